// File: rtl/fifo_read_packer.sv
// Read-side FIFO consumer: issues reads, absorbs the one-cycle read latency and packs PACK lanes
// LSB-first into a wide valid/ready word, with flush support for partial end-of-message words.
module fifo_read_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int CNT_W      = $clog2(PACK + 1)
) (
  input  logic                         read_clk,
  input  logic                         read_reset_n,
  input  logic                         fifo_empty,
  output logic                         fifo_read_en,
  input  logic [DATA_WIDTH-1:0]        fifo_read_data,
  input  logic                         flush,
  output logic                         flush_busy,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH*PACK-1:0]   out_data,
  output logic [PACK-1:0]              out_keep,
  output logic                         out_last
);

  logic [DATA_WIDTH*PACK-1:0] acc;
  logic [DATA_WIDTH*PACK-1:0] acc_next;
  logic [CNT_W-1:0]           fill_cnt;
  logic [CNT_W-1:0]           fill_eff;
  logic [CNT_W-1:0]           fill_next;
  logic [CNT_W:0]             inflight;
  logic [PACK-1:0]            keep_mask;
  logic                       pend;
  logic                       out_free;
  logic                       move;
  logic                       flush_busy_next;

  // A word in flight (pend) counts against capacity so reads never overrun the accumulator.
  always_comb begin
    out_free     = !out_valid || out_ready;
    move         = out_free && ((fill_cnt == CNT_W'(PACK)) ||
                                (flush_busy && !pend && (fill_cnt != '0)));
    fill_eff     = move ? '0 : fill_cnt;
    inflight     = {1'b0, fill_eff} + {{CNT_W{1'b0}}, pend};
    fifo_read_en = read_reset_n && !fifo_empty && !flush_busy &&
                   (inflight < (CNT_W + 1)'(PACK));
  end

  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < PACK; i++) begin
      keep_mask[i] = (CNT_W'(i) < fill_cnt);
    end
  end

  // Accumulator is cleared on each move, so unfilled lanes always read as zero.
  always_comb begin
    acc_next  = move ? '0 : acc;
    fill_next = fill_eff;
    if (pend && (fill_eff != CNT_W'(PACK))) begin
      for (int i = 0; i < PACK; i++) begin
        if (fill_eff == CNT_W'(i)) begin
          acc_next[i*DATA_WIDTH +: DATA_WIDTH] = fifo_read_data;
        end
      end
      fill_next = fill_eff + CNT_W'(1);
    end
  end

  always_comb begin
    flush_busy_next = flush_busy;
    if (!flush_busy) begin
      flush_busy_next = flush;
    end else if (move || ((fill_cnt == '0) && !pend)) begin
      flush_busy_next = 1'b0;
    end
  end

  always_ff @(posedge read_clk) begin
    if (!read_reset_n) begin
      acc        <= '0;
      fill_cnt   <= '0;
      pend       <= 1'b0;
      flush_busy <= 1'b0;
    end else begin
      acc        <= acc_next;
      fill_cnt   <= fill_next;
      pend       <= fifo_read_en;
      flush_busy <= flush_busy_next;
    end
  end

  always_ff @(posedge read_clk) begin
    if (!read_reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (move) begin
      out_valid <= 1'b1;
      out_data  <= acc;
      out_keep  <= keep_mask;
      out_last  <= flush_busy;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_read_packer.sv
// Bench for fifo_read_packer: a queue-based FIFO model feeds the DUT and a byte-packing model
// predicts the output word stream, including flush-terminated partial words.
module tb_fifo_read_packer;

  localparam int DW   = 8;
  localparam int PACK = 4;

  typedef struct {
    logic [DW*PACK-1:0] data;
    logic [PACK-1:0]    keep;
    logic               last;
  } word_t;

  logic               read_clk;
  logic               read_reset_n;
  logic               fifo_empty;
  logic               fifo_read_en;
  logic [DW-1:0]      fifo_read_data;
  logic               flush;
  logic               flush_busy;
  logic               out_valid;
  logic               out_ready;
  logic [DW*PACK-1:0] out_data;
  logic [PACK-1:0]    out_keep;
  logic               out_last;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] model_acc[$];
  word_t         exp_q[$];
  word_t         got_q[$];
  int            test_count;
  int            fail_count;
  int            read_count;
  logic          hold_chk;
  logic [37:0]   hold_val;

  fifo_read_packer #(.DATA_WIDTH(DW), .PACK(PACK)) dut (
    .read_clk      (read_clk),
    .read_reset_n  (read_reset_n),
    .fifo_empty    (fifo_empty),
    .fifo_read_en  (fifo_read_en),
    .fifo_read_data(fifo_read_data),
    .flush         (flush),
    .flush_busy    (flush_busy),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_keep      (out_keep),
    .out_last      (out_last)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void model_emit(input logic last);
    word_t w;
    w.data = '0;
    w.keep = '0;
    w.last = last;
    for (int i = 0; i < model_acc.size(); i++) begin
      w.data[i*DW +: DW] = model_acc[i];
      w.keep[i]          = 1'b1;
    end
    exp_q.push_back(w);
    model_acc.delete();
  endfunction

  function automatic void model_read(input logic [DW-1:0] b);
    model_acc.push_back(b);
    if (model_acc.size() == PACK) model_emit(1'b0);
  endfunction

  // One clock cycle: called at negedge with inputs set, returns at the following negedge.
  task automatic applyStimulus();
    logic          did_read;
    logic [DW-1:0] rd_byte;
    word_t         w;
    did_read   = 1'b0;
    rd_byte    = '0;
    fifo_empty = (fifo_q.size() == 0);
    #1;
    checkOutput("read_while_empty", 64'(fifo_read_en && fifo_empty), 64'd0);
    if (!read_reset_n) checkOutput("read_in_reset", 64'(fifo_read_en), 64'd0);
    if (hold_chk) checkOutput("hold_stable", 64'({out_valid, out_last, out_keep, out_data}), 64'(hold_val));
    hold_chk = read_reset_n && out_valid && !out_ready;
    hold_val = {out_valid, out_last, out_keep, out_data};
    if (read_reset_n && out_valid && out_ready) begin
      w.data = out_data;
      w.keep = out_keep;
      w.last = out_last;
      got_q.push_back(w);
    end
    if (fifo_read_en && (fifo_q.size() > 0)) begin
      rd_byte  = fifo_q.pop_front();
      did_read = 1'b1;
      read_count++;
      model_read(rd_byte);
    end
    if (flush && read_reset_n && (model_acc.size() > 0)) model_emit(1'b1);
    @(posedge read_clk);
    #1;
    fifo_read_data = did_read ? rd_byte : DW'($urandom);
    @(negedge read_clk);
  endtask

  task automatic drain_and_compare(input string tag);
    int    cycles;
    word_t g;
    word_t e;
    out_ready = 1'b1;
    flush     = 1'b0;
    cycles    = 0;
    while ((cycles < 400) && !((fifo_q.size() == 0) && (model_acc.size() == 0) &&
           (got_q.size() >= exp_q.size()) && !out_valid && !flush_busy)) begin
      applyStimulus();
      cycles++;
    end
    checkOutput({tag, "_timeout"}, 64'(cycles >= 400), 64'd0);
    checkOutput({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while ((got_q.size() > 0) && (exp_q.size() > 0)) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checkOutput({tag, "_data"}, 64'(g.data), 64'(e.data));
      checkOutput({tag, "_keep"}, 64'(g.keep), 64'(e.keep));
      checkOutput({tag, "_last"}, 64'(g.last), 64'(e.last));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int start_reads;
    int pushed;
    test_count     = 0;
    fail_count     = 0;
    read_count     = 0;
    hold_chk       = 1'b0;
    hold_val       = '0;
    read_reset_n   = 1'b0;
    fifo_empty     = 1'b1;
    fifo_read_data = '0;
    flush          = 1'b0;
    out_ready      = 1'b0;
    @(negedge read_clk);

    repeat (3) applyStimulus();
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_data", 64'(out_data), 64'd0);
    checkOutput("reset_keep", 64'(out_keep), 64'd0);
    checkOutput("reset_last", 64'(out_last), 64'd0);
    checkOutput("reset_busy", 64'(flush_busy), 64'd0);
    read_reset_n = 1'b1;

    // Two full words streamed with the sink always ready
    for (int i = 1; i <= 8; i++) fifo_q.push_back(DW'(i * 8'h11));
    drain_and_compare("t1");

    // Backpressure: reads must stop once accumulator and output register are both full
    for (int i = 0; i < 12; i++) fifo_q.push_back(DW'(8'h30 + i));
    out_ready   = 1'b0;
    start_reads = read_count;
    repeat (20) applyStimulus();
    checkOutput("t2_reads_stalled", 64'(read_count - start_reads), 64'd8);
    checkOutput("t2_no_output", 64'(got_q.size()), 64'd0);
    drain_and_compare("t2");

    // Random arrivals and random sink readiness
    pushed = 0;
    for (int c = 0; c < 400; c++) begin
      if ((pushed < 160) && ($urandom_range(0, 3) != 0)) begin
        fifo_q.push_back(DW'($urandom));
        pushed++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    while (pushed < 160) begin
      fifo_q.push_back(DW'($urandom));
      pushed++;
    end
    drain_and_compare("rand");

    // Partial word closed by flush after all bytes are captured
    fifo_q.push_back(8'hA1);
    fifo_q.push_back(8'hA2);
    fifo_q.push_back(8'hA3);
    out_ready = 1'b1;
    repeat (5) applyStimulus();
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    drain_and_compare("t3");
    checkOutput("t3_busy_clear", 64'(flush_busy), 64'd0);

    // Flush coincides with the read of the third byte
    fifo_q.push_back(8'hB1);
    fifo_q.push_back(8'hB2);
    fifo_q.push_back(8'hB3);
    repeat (2) applyStimulus();
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    drain_and_compare("t4");

    // Flush with nothing accumulated: busy for one cycle, no word
    flush = 1'b1;
    applyStimulus();
    flush = 1'b0;
    checkOutput("t5_busy_set", 64'(flush_busy), 64'd1);
    checkOutput("t5_no_valid0", 64'(out_valid), 64'd0);
    applyStimulus();
    checkOutput("t5_busy_clear", 64'(flush_busy), 64'd0);
    repeat (3) applyStimulus();
    checkOutput("t5_no_valid", 64'(out_valid), 64'd0);
    checkOutput("t5_no_word", 64'(got_q.size()), 64'd0);

    // Reset mid-stream with output held and two lanes filled
    for (int i = 0; i < 6; i++) fifo_q.push_back(DW'(8'hC1 + i));
    out_ready = 1'b0;
    repeat (12) applyStimulus();
    checkOutput("t6_pre_valid", 64'(out_valid), 64'd1);
    read_reset_n = 1'b0;
    for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(i));
    applyStimulus();
    checkOutput("t6_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_data", 64'(out_data), 64'd0);
    checkOutput("t6_keep", 64'(out_keep), 64'd0);
    checkOutput("t6_last", 64'(out_last), 64'd0);
    checkOutput("t6_busy", 64'(flush_busy), 64'd0);
    model_acc.delete();
    exp_q.delete();
    got_q.delete();
    read_reset_n = 1'b1;
    drain_and_compare("t6");

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
